regfile_2r1w: RTL and testbench

- Parametrised integer register file, successor to the single-port register file used by the execute stage.
- Two independent synchronous read ports and one write port.
- Optional hardwired-zero register 0, optional write-to-read bypass.
- Per-register busy scoreboard so the decode stage can detect pending writebacks.

---
 rtl/regfile_2r1w.sv | 114 +++++++++++
 tb/tb_regfile_2r1w.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised integer register file with two registered read
// ports, one write port, an optional hardwired-zero register 0, an optional
// write-to-read bypass and a per-register busy scoreboard.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   wen, waddr, wdata         write port
//   ren0, raddr0              read port 0 request
//   rdata0, rbusy0            read port 0 data/busy, registered (latency 1)
//   ren1, raddr1              read port 1 request
//   rdata1, rbusy1            read port 1 data/busy, registered (latency 1)
//   bset, bsaddr              mark a register busy (producer issued)
//   busy_any                  OR of all busy bits
module regfile_2r1w #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren0,
  input  logic [ADDR_WIDTH-1:0] raddr0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  rbusy0,
  input  logic                  ren1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rbusy1,
  input  logic                  bset,
  input  logic [ADDR_WIDTH-1:0] bsaddr,
  output logic                  busy_any
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;

  logic                  wr_ok;
  logic                  bs_ok;
  logic [DATA_WIDTH-1:0] rd_next0, rd_next1;
  logic                  rb_next0, rb_next1;

  // Register 0 swallows writes and busy marks when it is hardwired to zero.
  assign wr_ok = wen  && !((ZERO_REG != 0) && (waddr  == '0));
  assign bs_ok = bset && !((ZERO_REG != 0) && (bsaddr == '0));

  // Clear from the writeback is applied first so a same-index bset wins.
  always_comb begin
    busy_next = busy;
    if (wr_ok) busy_next[waddr]  = 1'b0;
    if (bs_ok) busy_next[bsaddr] = 1'b1;
  end

  always_comb begin
    rd_next0 = mem[raddr0];
    rb_next0 = busy[raddr0];
    if ((ZERO_REG != 0) && (raddr0 == '0)) begin
      rd_next0 = '0;
      rb_next0 = 1'b0;
    end else if ((BYPASS != 0) && wr_ok && (raddr0 == waddr)) begin
      rd_next0 = wdata;
      rb_next0 = bs_ok && (bsaddr == raddr0);
    end
  end

  always_comb begin
    rd_next1 = mem[raddr1];
    rb_next1 = busy[raddr1];
    if ((ZERO_REG != 0) && (raddr1 == '0)) begin
      rd_next1 = '0;
      rb_next1 = 1'b0;
    end else if ((BYPASS != 0) && wr_ok && (raddr1 == waddr)) begin
      rd_next1 = wdata;
      rb_next1 = bs_ok && (bsaddr == raddr1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) mem[waddr] <= wdata;
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0 <= '0;
      rbusy0 <= 1'b0;
      rdata1 <= '0;
      rbusy1 <= 1'b0;
    end else begin
      if (ren0) begin
        rdata0 <= rd_next0;
        rbusy0 <= rb_next0;
      end
      if (ren1) begin
        rdata1 <= rd_next1;
        rbusy1 <= rb_next1;
      end
    end
  end

  assign busy_any = |busy;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed testbench for regfile_2r1w. Two instances share all inputs: the
// default one (ZERO_REG=1, BYPASS=1) and an alternate (ZERO_REG=0, BYPASS=0).
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic        ren0, ren1;
  logic [4:0]  raddr0, raddr1;
  logic        bset;
  logic [4:0]  bsaddr;

  logic [63:0] rdata0, rdata1, a_rdata0, a_rdata1;
  logic        rbusy0, rbusy1, a_rbusy0, a_rbusy1;
  logic        busy_any, a_busy_any;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren0(ren0), .raddr0(raddr0), .rdata0(rdata0), .rbusy0(rbusy0),
    .ren1(ren1), .raddr1(raddr1), .rdata1(rdata1), .rbusy1(rbusy1),
    .bset(bset), .bsaddr(bsaddr), .busy_any(busy_any)
  );

  regfile_2r1w #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .ZERO_REG(0), .BYPASS(0)) dut_alt (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren0(ren0), .raddr0(raddr0), .rdata0(a_rdata0), .rbusy0(a_rbusy0),
    .ren1(ren1), .raddr1(raddr1), .rdata1(a_rdata1), .rbusy1(a_rbusy1),
    .bset(bset), .bsaddr(bsaddr), .busy_any(a_busy_any)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; waddr = '0; wdata = '0;
    ren0 = 1'b0; raddr0 = '0; ren1 = 1'b0; raddr1 = '0;
    bset = 1'b0; bsaddr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    n_checks++;
    if (rdata0 !== 64'd0 || rdata1 !== 64'd0 || rbusy0 !== 1'b0 || rbusy1 !== 1'b0 || busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: rdata0=%h rdata1=%h rbusy0=%b rbusy1=%b busy_any=%b, expected all 0",
               rdata0, rdata1, rbusy0, rbusy1, busy_any);
    end
    rst = 1'b0;
    tick();
    // preload 1..31 with distinct values, mark r4 busy
    for (int i = 1; i < 32; i++) begin
      wen = 1'b1; waddr = 5'(i); wdata = 64'h0100_0000_0000_0000 + 64'(i);
      tick();
    end
    wen = 1'b0;
    bset = 1'b1; bsaddr = 5'd4;
    ren0 = 1'b1; raddr0 = 5'd5; ren1 = 1'b1; raddr1 = 5'd31;
    tick();
    bset = 1'b0; ren0 = 1'b0; ren1 = 1'b0;
    n_checks++;
    if (rdata0 !== 64'h0100_0000_0000_0005 || rdata1 !== 64'h0100_0000_0000_001f || busy_any !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_preload: rdata0=%h rdata1=%h busy_any=%b, expected 0100000000000005 010000000000001f 1",
               rdata0, rdata1, busy_any);
    end
    // mid-cycle assertion with a write pending
    wen = 1'b1; waddr = 5'd6; wdata = 64'hFFFF;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (rdata0 !== 64'd0 || rdata1 !== 64'd0 || busy_any !== 1'b0 || a_rdata0 !== 64'd0 || a_busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: rdata0=%h rdata1=%h busy_any=%b a_rdata0=%h a_busy_any=%b, expected all 0",
               rdata0, rdata1, busy_any, a_rdata0, a_busy_any);
    end
    tick();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) begin
      ren0 = 1'b1; raddr0 = 5'(i); ren1 = 1'b1; raddr1 = 5'(i);
      tick();
      n_checks++;
      if (rdata0 !== 64'd0 || rdata1 !== 64'd0 || rbusy0 !== 1'b0 || a_rdata0 !== 64'd0 || busy_any !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_clear_r%0d: rdata0=%h rdata1=%h rbusy0=%b a_rdata0=%h busy_any=%b, expected 0",
                 i, rdata0, rdata1, rbusy0, a_rdata0, busy_any);
      end
    end
    idle();
  endtask

  task automatic test_basic();
    wen = 1'b1; waddr = 5'd5; wdata = 64'hDEADBEEF_00000005;
    tick();
    wen = 1'b0;
    ren0 = 1'b1; raddr0 = 5'd5; ren1 = 1'b1; raddr1 = 5'd5;
    tick();
    n_checks++;
    if (rdata0 !== 64'hDEADBEEF_00000005 || rdata1 !== 64'hDEADBEEF_00000005 || a_rdata0 !== 64'hDEADBEEF_00000005) begin
      n_fail++;
      $display("FAIL basic_read: rdata0=%h rdata1=%h a_rdata0=%h, expected deadbeef00000005",
               rdata0, rdata1, a_rdata0);
    end
    ren0 = 1'b0; raddr0 = 5'd3; raddr1 = 5'd3;
    tick();
    n_checks++;
    if (rdata0 !== 64'hDEADBEEF_00000005 || rdata1 !== 64'd0) begin
      n_fail++;
      $display("FAIL basic_hold: rdata0=%h rdata1=%h, expected deadbeef00000005 0", rdata0, rdata1);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    wen = 1'b1; waddr = 5'd0; wdata = 64'h1234;
    tick();
    wen = 1'b0;
    ren0 = 1'b1; raddr0 = 5'd0;
    tick();
    n_checks++;
    if (rdata0 !== 64'd0 || a_rdata0 !== 64'h1234) begin
      n_fail++;
      $display("FAIL zero_write: rdata0=%h a_rdata0=%h, expected 0 1234", rdata0, a_rdata0);
    end
    ren0 = 1'b0;
    bset = 1'b1; bsaddr = 5'd0;
    tick();
    bset = 1'b0;
    ren0 = 1'b1; raddr0 = 5'd0;
    tick();
    ren0 = 1'b0;
    n_checks++;
    if (busy_any !== 1'b0 || rbusy0 !== 1'b0 || a_busy_any !== 1'b1 || a_rbusy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_bset: busy_any=%b rbusy0=%b a_busy_any=%b a_rbusy0=%b, expected 0 0 1 1",
               busy_any, rbusy0, a_busy_any, a_rbusy0);
    end
    wen = 1'b1; waddr = 5'd0; wdata = 64'd0;
    tick();
    wen = 1'b0;
    n_checks++;
    if (a_busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_clear_alt: a_busy_any=%b, expected 0", a_busy_any);
    end
    idle();
  endtask

  task automatic test_bypass();
    wen = 1'b1; waddr = 5'd7; wdata = 64'h11;
    tick();
    wdata = 64'h22; ren0 = 1'b1; raddr0 = 5'd7;
    tick();
    n_checks++;
    if (rdata0 !== 64'h22 || a_rdata0 !== 64'h11) begin
      n_fail++;
      $display("FAIL bypass_data: rdata0=%h a_rdata0=%h, expected 22 11", rdata0, a_rdata0);
    end
    wen = 1'b0;
    tick();
    n_checks++;
    if (rdata0 !== 64'h22 || a_rdata0 !== 64'h22) begin
      n_fail++;
      $display("FAIL bypass_after: rdata0=%h a_rdata0=%h, expected 22 22", rdata0, a_rdata0);
    end
    wen = 1'b1; wdata = 64'h33; bset = 1'b1; bsaddr = 5'd7;
    tick();
    n_checks++;
    if (rdata0 !== 64'h33 || rbusy0 !== 1'b1 || a_rdata0 !== 64'h22 || a_rbusy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_bset: rdata0=%h rbusy0=%b a_rdata0=%h a_rbusy0=%b, expected 33 1 22 0",
               rdata0, rbusy0, a_rdata0, a_rbusy0);
    end
    bset = 1'b0; ren0 = 1'b0; wdata = 64'h44;
    tick();
    idle();
  endtask

  task automatic test_scoreboard();
    n_checks++;
    if (busy_any !== 1'b0 || a_busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_idle: busy_any=%b a_busy_any=%b, expected 0 0", busy_any, a_busy_any);
    end
    bset = 1'b1; bsaddr = 5'd9;
    tick();
    bset = 1'b0;
    ren0 = 1'b1; raddr0 = 5'd9;
    tick();
    ren0 = 1'b0;
    n_checks++;
    if (busy_any !== 1'b1 || rbusy0 !== 1'b1 || a_rbusy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_set: busy_any=%b rbusy0=%b a_rbusy0=%b, expected 1 1 1", busy_any, rbusy0, a_rbusy0);
    end
    wen = 1'b1; waddr = 5'd9; wdata = 64'h99;
    tick();
    wen = 1'b0;
    n_checks++;
    if (busy_any !== 1'b0 || a_busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_clear: busy_any=%b a_busy_any=%b, expected 0 0", busy_any, a_busy_any);
    end
    wen = 1'b1; waddr = 5'd9; wdata = 64'hAA; bset = 1'b1; bsaddr = 5'd9;
    tick();
    wen = 1'b0; bset = 1'b0;
    ren0 = 1'b1; raddr0 = 5'd9;
    tick();
    ren0 = 1'b0;
    n_checks++;
    if (busy_any !== 1'b1 || rdata0 !== 64'hAA || rbusy0 !== 1'b1 || a_rdata0 !== 64'hAA || a_rbusy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_set_wins: busy_any=%b rdata0=%h rbusy0=%b a_rdata0=%h a_rbusy0=%b, expected 1 aa 1 aa 1",
               busy_any, rdata0, rbusy0, a_rdata0, a_rbusy0);
    end
    wen = 1'b1; waddr = 5'd9; wdata = 64'hBB; bset = 1'b1; bsaddr = 5'd10;
    tick();
    wen = 1'b0; bset = 1'b0;
    ren0 = 1'b1; raddr0 = 5'd9; ren1 = 1'b1; raddr1 = 5'd10;
    tick();
    ren0 = 1'b0; ren1 = 1'b0;
    n_checks++;
    if (rdata0 !== 64'hBB || rbusy0 !== 1'b0 || rbusy1 !== 1'b1 || busy_any !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_diff_idx: rdata0=%h rbusy0=%b rbusy1=%b busy_any=%b, expected bb 0 1 1",
               rdata0, rbusy0, rbusy1, busy_any);
    end
    wen = 1'b1; waddr = 5'd10; wdata = 64'h0;
    tick();
    idle();
    n_checks++;
    if (busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_final_clear: busy_any=%b, expected 0", busy_any);
    end
  endtask

  task automatic test_dual_sweep();
    for (int i = 0; i < 32; i++) begin
      wen = 1'b1; waddr = 5'(i); wdata = 64'(i * 3);
      tick();
    end
    wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ren0 = 1'b1; raddr0 = 5'(i); ren1 = 1'b1; raddr1 = 5'(31 - i);
      tick();
      n_checks++;
      if (rdata0 !== 64'(i * 3) || rdata1 !== 64'((31 - i) * 3) ||
          a_rdata0 !== 64'(i * 3) || a_rdata1 !== 64'((31 - i) * 3)) begin
        n_fail++;
        $display("FAIL sweep_%0d: rdata0=%h rdata1=%h a_rdata0=%h a_rdata1=%h, expected %h %h",
                 i, rdata0, rdata1, a_rdata0, a_rdata1, 64'(i * 3), 64'((31 - i) * 3));
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_dual_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
